// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer fetch stage.
//  - RGB565 field positions inside one 16-bit pixel
//  - default scan geometry (row/column address widths)
//  - framebuffer RAM word layout (top-half pixel in the upper 16 bits)
//  - bank swap FSM state encoding
//  - channel expansion and bitplane select helpers
package fb_pkg;

    localparam int ROW_BITS_DEF = 4;
    localparam int COL_BITS_DEF = 6;
    localparam int MASK_W       = 6;

    localparam int PIX_W        = 16;
    localparam int RAM_W        = 32;
    localparam int TOP_PIX_LSB  = 16;
    localparam int BOT_PIX_LSB  = 0;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        SWAP_IDLE    = 2'd0,
        SWAP_PENDING = 2'd1,
        SWAP_HELD    = 2'd2
    } swap_state_t;

    // 5-bit channel to 6 bits: replicate the MSB into the new LSB so that
    // full scale stays full scale.
    function automatic logic [5:0] expand5(input logic [4:0] c5);
        return {c5, c5[4]};
    endfunction

    // Bit of a 6-bit channel selected by the bitplane mask. A zero mask
    // blanks; a non-one-hot mask ORs the selected bits together.
    function automatic logic plane_bit(input logic [5:0] c6, input logic [MASK_W-1:0] mask);
        return |(c6 & mask);
    endfunction

endpackage

// File: rtl/rgb565_bitplane.sv
// Combinational RGB565 -> 3-bit bitplane select for a single pixel.
// Ports:
//  pixel  in   16  RGB565 pixel (R[15:11], G[10:5], B[4:0])
//  mask   in   6   one-hot bitplane select, 0 = blank
//  rgb    out  3   {R,G,B} plane bits
module rgb565_bitplane
    import fb_pkg::*;
(
    input  logic [PIX_W-1:0]  pixel,
    input  logic [MASK_W-1:0] mask,
    output logic [2:0]        rgb
);

    logic [5:0] r6;
    logic [5:0] g6;
    logic [5:0] b6;

    assign r6 = expand5(pixel[R_MSB:R_LSB]);
    assign g6 = pixel[G_MSB:G_LSB];
    assign b6 = expand5(pixel[B_MSB:B_LSB]);

    assign rgb = {plane_bit(r6, mask), plane_bit(g6, mask), plane_bit(b6, mask)};

endmodule

// File: rtl/framebuffer_fetch.sv
// Pixel data stage downstream of the matrix scan timing generator.
// Issues framebuffer reads for each column load, turns the returned RGB565
// pixel pair into HUB75 colour bits for the current brightness bitplane,
// and owns the front/back bank swap, which only happens at frame boundaries.
// Ports:
//  clk_in          in   1   clock shared with scan timing
//  reset_n         in   1   asynchronous active-low reset
//  column_address  in   6   column being loaded
//  row_address     in   4   row being loaded
//  brightness_mask in   6   one-hot bitplane select, 0 = blank
//  pixel_load_en   in   1   column load cycle
//  row_latch       in   1   row latch pulse
//  ram_rd_en       out  1   framebuffer read strobe
//  ram_addr        out  11  {active_bank, row_address, column_address}
//  ram_data        in   32  {top pixel, bottom pixel}, valid 1 cycle after read
//  rgb_top         out  3   {R,G,B} for upper half
//  rgb_bot         out  3   {R,G,B} for lower half
//  swap_req        in   1   writer has a complete back buffer (level)
//  swap_ack        out  1   one-cycle pulse when banks swap
//  active_bank     out  1   bank currently displayed
module framebuffer_fetch
    import fb_pkg::*;
#(
    parameter int OUT_DELAY = 0,
    parameter int ROW_BITS  = ROW_BITS_DEF,
    parameter int COL_BITS  = COL_BITS_DEF
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic [COL_BITS-1:0]        column_address,
    input  logic [ROW_BITS-1:0]        row_address,
    input  logic [MASK_W-1:0]          brightness_mask,
    input  logic                       pixel_load_en,
    input  logic                       row_latch,
    output logic                       ram_rd_en,
    output logic [ROW_BITS+COL_BITS:0] ram_addr,
    input  logic [RAM_W-1:0]           ram_data,
    output logic [2:0]                 rgb_top,
    output logic [2:0]                 rgb_bot,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic                       active_bank
);

    logic              vld_p0;
    logic [MASK_W-1:0] mask_p0;
    logic [2:0]        top_plane;
    logic [2:0]        bot_plane;
    logic [2:0]        top_p1;
    logic [2:0]        bot_p1;

    logic              row_latch_q;
    logic              frame_boundary;

    swap_state_t       state;
    swap_state_t       state_nxt;
    logic              do_swap;

    // ---- stage p0: read issue; mask travels with the request ----
    assign ram_rd_en = pixel_load_en;
    assign ram_addr  = {active_bank, row_address, column_address};

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0  <= 1'b0;
            mask_p0 <= '0;
        end else begin
            vld_p0  <= pixel_load_en;
            mask_p0 <= brightness_mask;
        end
    end

    // ---- stage p1: RAM data arrives, bitplane select, output register ----
    rgb565_bitplane u_top_plane (
        .pixel (ram_data[TOP_PIX_LSB +: PIX_W]),
        .mask  (mask_p0),
        .rgb   (top_plane)
    );

    rgb565_bitplane u_bot_plane (
        .pixel (ram_data[BOT_PIX_LSB +: PIX_W]),
        .mask  (mask_p0),
        .rgb   (bot_plane)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            top_p1 <= '0;
            bot_p1 <= '0;
        end else if (vld_p0) begin
            top_p1 <= top_plane;
            bot_p1 <= bot_plane;
        end
    end

    // ---- stage p2: optional IO alignment delay ----
    // A plain shift of a held value is itself held, so these stages need
    // no valid qualification.
    if (OUT_DELAY == 0) begin : g_no_delay
        assign rgb_top = top_p1;
        assign rgb_bot = bot_p1;
    end else begin : g_delay
        logic [2:0] top_p2 [OUT_DELAY];
        logic [2:0] bot_p2 [OUT_DELAY];

        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < OUT_DELAY; i++) begin
                    top_p2[i] <= '0;
                    bot_p2[i] <= '0;
                end
            end else begin
                top_p2[0] <= top_p1;
                bot_p2[0] <= bot_p1;
                for (int i = 1; i < OUT_DELAY; i++) begin
                    top_p2[i] <= top_p2[i-1];
                    bot_p2[i] <= bot_p2[i-1];
                end
            end
        end

        assign rgb_top = top_p2[OUT_DELAY-1];
        assign rgb_bot = bot_p2[OUT_DELAY-1];
    end

    // ---- bank swap control ----
    // The frame ends when the last row of the lowest bitplane is latched.
    // The row latch follows the load burst, so a swap here never splits a row.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            row_latch_q <= 1'b0;
        end else begin
            row_latch_q <= row_latch;
        end
    end

    assign frame_boundary = row_latch && !row_latch_q &&
                            (row_address == {ROW_BITS{1'b1}}) &&
                            (brightness_mask == MASK_W'(1));

    // A request first seen in a boundary cycle only reaches PENDING there,
    // so it waits for the following boundary.
    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        case (state)
            SWAP_IDLE: begin
                if (swap_req) begin
                    state_nxt = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (!swap_req) begin
                    state_nxt = SWAP_IDLE;
                end else if (frame_boundary) begin
                    do_swap   = 1'b1;
                    state_nxt = SWAP_HELD;
                end
            end
            SWAP_HELD: begin
                if (!swap_req) begin
                    state_nxt = SWAP_IDLE;
                end
            end
            default: begin
                state_nxt = SWAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SWAP_IDLE;
            swap_ack    <= 1'b0;
            active_bank <= 1'b0;
        end else begin
            state    <= state_nxt;
            swap_ack <= do_swap;
            if (do_swap) begin
                active_bank <= ~active_bank;
            end
        end
    end

endmodule
